// File: rtl/instr_dispatch_sequencer.sv
// Instruction dispatch sequencer: absorbs the FIFO word stream in a skid buffer,
// parses headers and routes header plus payload words to one of NUM_UNITS engines.
module instr_dispatch_sequencer #(
  parameter int NUM_UNITS  = 4,
  parameter int SKID_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          unit_data,
  output logic [NUM_UNITS-1:0] unit_valid,
  output logic                 unit_sop,
  output logic                 unit_eop,
  input  logic [NUM_UNITS-1:0] unit_ready,
  input  logic [NUM_UNITS-1:0] unit_busy,
  output logic                 err_unit,
  output logic                 err_opcode,
  output logic                 err_overflow,
  output logic                 idle
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(SKID_DEPTH);
  localparam logic [OCC_W:0]   READY_LIMIT = (OCC_W + 1)'(SKID_DEPTH - 1);

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_DISPATCH = 4'h1;
  localparam logic [3:0] OP_SYNC     = 4'h2;

  typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_SYNC, ST_DROP} state_e;

  logic [31:0]      mem_q [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_flight_q, in_flight_d;
  logic             overflow_q, overflow_d;
  state_e           state_q, state_d;
  logic [3:0]       unit_q, unit_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;

  logic                 head_valid;
  logic [31:0]          head;
  logic [3:0]           hdr_op;
  logic [3:0]           hdr_unit;
  logic [LEN_W-1:0]     hdr_len;
  logic                 hdr_unit_ok;
  logic                 push_ok;
  logic                 pop;
  logic [NUM_UNITS-1:0] valid_mask;
  logic                 sop, eop, err_u, err_op;

  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [3:0] idx);
    logic [NUM_UNITS-1:0] oh;
    for (int u = 0; u < NUM_UNITS; u++) begin
      oh[u] = (idx == 4'(u));
    end
    return oh;
  endfunction

  assign head_valid  = (occ_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign hdr_op      = head[31:28];
  assign hdr_unit    = head[27:24];
  assign hdr_len     = head[LEN_W-1:0];
  assign hdr_unit_ok = ({1'b0, hdr_unit} < 5'(NUM_UNITS));

  // Ready budget counts the word the source may already have in flight.
  assign in_ready = ({1'b0, occ_q} + (OCC_W + 1)'(in_flight_q)) <= READY_LIMIT;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case tree can leave it unassigned and infer a latch.
  always_comb begin
    pop         = 1'b0;
    valid_mask  = '0;
    sop         = 1'b0;
    eop         = 1'b0;
    err_u       = 1'b0;
    err_op      = 1'b0;
    state_d     = state_q;
    unit_d      = unit_q;
    remaining_d = remaining_q;

    unique case (state_q)
      ST_HDR: begin
        if (head_valid) begin
          unique case (hdr_op)
            OP_DISPATCH: begin
              if (hdr_unit_ok) begin
                valid_mask = unit_onehot(hdr_unit);
                sop        = 1'b1;
                eop        = (hdr_len == '0);
                pop        = |(unit_ready & valid_mask);
                if (pop && (hdr_len != '0)) begin
                  state_d     = ST_PAYLOAD;
                  unit_d      = hdr_unit;
                  remaining_d = hdr_len;
                end
              end else begin
                pop   = 1'b1;
                err_u = 1'b1;
                if (hdr_len != '0) begin
                  state_d     = ST_DROP;
                  remaining_d = hdr_len;
                end
              end
            end
            OP_SYNC: begin
              pop     = 1'b1;
              state_d = ST_SYNC;
            end
            OP_NOP: pop = 1'b1;
            default: begin
              pop    = 1'b1;
              err_op = 1'b1;
            end
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (head_valid) begin
          valid_mask = unit_onehot(unit_q);
          eop        = (remaining_q == LEN_W'(1));
          pop        = |(unit_ready & valid_mask);
          if (pop) begin
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) state_d = ST_HDR;
          end
        end
      end
      ST_DROP: begin
        if (head_valid) begin
          pop         = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = ST_HDR;
        end
      end
      ST_SYNC: begin
        if (unit_busy == '0) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_comb begin
    push_ok     = in_valid && (occ_q != OCC_FULL);
    overflow_d  = overflow_q | (in_valid && (occ_q == OCC_FULL));
    wr_ptr_d    = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    in_flight_d = in_ready;
    occ_d       = occ_q;
    if (push_ok && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (!push_ok && pop) occ_d = occ_q - OCC_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      in_flight_q <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= ST_HDR;
      unit_q      <= '0;
      remaining_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      in_flight_q <= in_flight_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      unit_q      <= unit_d;
      remaining_q <= remaining_d;
    end
  end

  // NOTE: the storage array has no reset; occ_q gates every read, so stale
  // contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_data;
  end

  assign unit_data    = head;
  assign unit_valid   = valid_mask;
  assign unit_sop     = sop;
  assign unit_eop     = eop;
  assign err_unit     = err_u;
  assign err_opcode   = err_op;
  assign err_overflow = overflow_q;
  assign idle         = (occ_q == '0) && (state_q == ST_HDR) && (unit_busy == '0);

endmodule
